// File: rtl/c1_pool_window_builder_pkg.sv
// c1_pkg: shared constants for the C1 pooling path.
// Both the window builder (packer) and the max-pooling unit (unpacker)
// import this package so the byte-lane order of the 32-bit pool word
// is defined in exactly one place.
package c1_pkg;

    localparam int C1_W     = 28;           // feature-map width
    localparam int C1_H     = 28;           // feature-map height
    localparam int C1_CH    = 6;            // channels per pixel
    localparam int C1_DW    = 8;            // bits per channel
    localparam int C1_PIX_W = C1_CH * C1_DW;

    // LSB positions of each window element inside the 32-bit pool word
    localparam int LANE_TL = 24;
    localparam int LANE_TR = 16;
    localparam int LANE_BL = 8;
    localparam int LANE_BR = 0;

    function automatic logic [31:0] pack_win(
        input logic [C1_DW-1:0] tl,
        input logic [C1_DW-1:0] tr,
        input logic [C1_DW-1:0] bl,
        input logic [C1_DW-1:0] br
    );
        logic [31:0] w;
        w = '0;
        w[LANE_TL +: C1_DW] = tl;
        w[LANE_TR +: C1_DW] = tr;
        w[LANE_BL +: C1_DW] = bl;
        w[LANE_BR +: C1_DW] = br;
        return w;
    endfunction

endpackage

// File: rtl/c1_line_buffer.sv
// c1_line_buffer: one row of C1 pixels (all channels per entry).
// Ports:
//   clk        - clock
//   i_we       - write enable
//   i_waddr    - write column
//   i_wdata    - pixel to store (C1_PIX_W bits)
//   i_raddr_a  - read column A, o_rdata_a combinational data
//   i_raddr_b  - read column B, o_rdata_b combinational data
// Storage has no reset; every entry is rewritten by an even row before use.
module c1_line_buffer
    import c1_pkg::*;
#(
    parameter int IMG_W = C1_W,
    parameter int AW    = $clog2(IMG_W)
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [AW-1:0]       i_waddr,
    input  logic [C1_PIX_W-1:0] i_wdata,
    input  logic [AW-1:0]       i_raddr_a,
    output logic [C1_PIX_W-1:0] o_rdata_a,
    input  logic [AW-1:0]       i_raddr_b,
    output logic [C1_PIX_W-1:0] o_rdata_b
);

    logic [C1_PIX_W-1:0] r_mem [IMG_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/c1_pool_window_builder.sv
// c1_pool_window_builder: turns the raster C1 pixel stream into 2x2
// pooling windows, one per odd-row/odd-column pixel.
// Ports:
//   clk, reset_n (async active-low)
//   clear               - synchronous frame restart, beats conv_valid
//   conv_valid          - pixel present this cycle
//   conv_ch0..5  [7:0]  - pixel channels
//   pool_valid          - one-cycle window pulse (registered)
//   pool_ch0..5  [31:0] - {TL, TR, BL, BR} per channel
//   frame_done          - pulses with the last window of a frame
module c1_pool_window_builder
    import c1_pkg::*;
#(
    parameter int IMG_W = C1_W,
    parameter int IMG_H = C1_H
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        conv_valid,
    input  logic [7:0]  conv_ch0,
    input  logic [7:0]  conv_ch1,
    input  logic [7:0]  conv_ch2,
    input  logic [7:0]  conv_ch3,
    input  logic [7:0]  conv_ch4,
    input  logic [7:0]  conv_ch5,
    output logic        pool_valid,
    output logic [31:0] pool_ch0,
    output logic [31:0] pool_ch1,
    output logic [31:0] pool_ch2,
    output logic [31:0] pool_ch3,
    output logic [31:0] pool_ch4,
    output logic [31:0] pool_ch5,
    output logic        frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]           r_col;
    logic [RW-1:0]           r_row;
    logic [C1_PIX_W-1:0]     r_bl_q;
    logic                    r_pool_valid;
    logic                    r_frame_done;
    logic [C1_CH-1:0][31:0]  r_win;

    logic [C1_PIX_W-1:0]     w_pix;
    logic [C1_PIX_W-1:0]     w_top_left;
    logic [C1_PIX_W-1:0]     w_top_right;
    logic [CW-1:0]           w_col_even;
    logic                    w_col_last;
    logic                    w_row_last;
    logic                    w_lb_we;

    assign w_pix      = {conv_ch5, conv_ch4, conv_ch3, conv_ch2, conv_ch1, conv_ch0};
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_lb_we    = conv_valid && !clear && !r_row[0];

    // On odd columns, col-1 is just col with the LSB cleared; this form
    // also stays in range at col 0 where the read result is unused.
    always_comb begin
        w_col_even    = r_col;
        w_col_even[0] = 1'b0;
    end

    c1_line_buffer #(
        .IMG_W (IMG_W),
        .AW    (CW)
    ) u_line_buffer (
        .clk       (clk),
        .i_we      (w_lb_we),
        .i_waddr   (r_col),
        .i_wdata   (w_pix),
        .i_raddr_a (w_col_even),
        .o_rdata_a (w_top_left),
        .i_raddr_b (r_col),
        .o_rdata_b (w_top_right)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_bl_q       <= '0;
            r_pool_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_win        <= '0;
        end else if (clear) begin
            r_col        <= '0;
            r_row        <= '0;
            r_pool_valid <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_pool_valid <= 1'b0;
            r_frame_done <= 1'b0;
            if (conv_valid) begin
                if (r_row[0]) begin
                    if (!r_col[0]) begin
                        r_bl_q <= w_pix;
                    end else begin
                        r_pool_valid <= 1'b1;
                        r_frame_done <= w_row_last && w_col_last;
                        for (int unsigned n = 0; n < C1_CH; n++) begin
                            r_win[n] <= pack_win(w_top_left [n*C1_DW +: C1_DW],
                                                 w_top_right[n*C1_DW +: C1_DW],
                                                 r_bl_q     [n*C1_DW +: C1_DW],
                                                 w_pix      [n*C1_DW +: C1_DW]);
                        end
                    end
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    assign pool_valid = r_pool_valid;
    assign frame_done = r_frame_done;
    assign pool_ch0   = r_win[0];
    assign pool_ch1   = r_win[1];
    assign pool_ch2   = r_win[2];
    assign pool_ch3   = r_win[3];
    assign pool_ch4   = r_win[4];
    assign pool_ch5   = r_win[5];

endmodule

// File: doc/c1_pool_window_builder.md
# c1_pool_window_builder

Transmit-side producer for the C1 2x2 max-pooling unit. Accepts the C1 convolution output as a raster-order pixel stream, 6 channels of 8 bits per pixel. Buffers one even row and, on each odd-row/odd-column pixel, emits one 2x2 window per channel, packed as {top_left, top_right, bottom_left, bottom_right}, with a single-cycle `pool_valid`. Sits between the C1 conv/ReLU stage and the max-pooling unit, and drives its `pool_valid`/`pool_ch0..5` inputs directly.

## Interface
Parameters:
- `IMG_W`, default 28: C1 feature-map width in pixels. Must be even, ≥2.
- `IMG_H`, default 28: C1 feature-map height in rows. Must be even, ≥2.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset_n`  in  1: reset is asynchronous and active-low.
- `clear`  in  1: synchronous frame restart. Has priority over `conv_valid`.
- `conv_valid`  in  1: one pixel (all 6 channels) is presented this cycle.
- `conv_ch0`..`conv_ch5`  in  8 each: unsigned pixel value per channel.
- `pool_valid`  out  1: one-cycle pulse; packed window valid.
- `pool_ch0`..`pool_ch5`  out  32 each: {TL[31:24], TR[23:16], BL[15:8], BR[7:0]}.
- `frame_done`  out  1: pulse coincident with the last `pool_valid` of a frame.

## Operation
- Counters: `col` runs 0..IMG_W-1 and `row` runs 0..IMG_H-1.
  - Both advance only on an accepted sample (`conv_valid`=1, `clear`=0).
  - `col` wraps to 0 and increments `row`. At (IMG_H-1, IMG_W-1) both wrap to 0 (next frame).
- Even row: write the sample into line buffer entry `col` (48 bits: all 6 channels). No output.
- Odd row, even `col`: latch the sample into the bottom-left register `bl_q`. No output.
- Odd row, odd `col`: register the outputs, per channel:
  - TL = `linebuf[col-1]`
  - TR = `linebuf[col]`
  - BL = `bl_q`
  - BR = the current input
  - Set `pool_valid`=1.
- `frame_done`=1 together with the window at (IMG_H-1, IMG_W-1).
- Idle behaviour: `pool_valid` and `frame_done` return to 0 on the next edge without a window. `pool_ch*` hold their last value.
- Values are passed through unmodified. No arithmetic, saturation or sign handling.
- `clear`=1 at an edge:
  - `row`, `col` ← 0; `pool_valid`, `frame_done` ← 0.
  - The concurrent sample is discarded.
  - Line buffer and `bl_q` are not cleared. Their stale contents are never read, because a fresh even row always overwrites the buffer before use.
- No backpressure: the downstream pooling unit accepts every cycle.
- Window rate: at most one window per 2 accepted samples; (IMG_W/2)·(IMG_H/2) windows per frame, i.e. 196 at 28x28.

## Timing
- Latency: a window-completing sample accepted at edge k gives `pool_valid`=1 during cycle k→k+1. The output is registered, one cycle.
- Back-to-back `conv_valid` is supported at full rate. Arbitrary gaps are allowed mid-row and mid-frame; state holds across the gap.
- Reset (async assert, any time including mid-frame):
  - `row`, `col`, `bl_q` ← 0
  - `pool_valid` ← 0, `frame_done` ← 0, `pool_ch0..5` ← 32'h0
  - Line buffer is not reset.
  - After deassertion, the first accepted sample is pixel (0,0).
- `clear` while `pool_valid` is high from the previous edge: the pulse still completes its one cycle. `clear` affects only the next registered values.

## Structure
- Shared package `c1_pkg`:
  - constants `C1_W`=28, `C1_H`=28, `C1_CH`=6, `C1_DW`=8
  - byte-lane positions of TL/TR/BL/BR within the 32-bit pool word
- The max-pooling unit imports the same package, so that pack and unpack order agree.
- One natural sub-module, `c1_line_buffer`:
  - IMG_W × 48-bit register array
  - one write port, two combinational read ports (`col-1`, `col`)
  - no reset on storage
- Top level holds the counters, `bl_q`, output registers and `frame_done` logic.

## Test plan
- Ramp frame: pixel (r,c) ch n = (r·28+c+n) mod 256, continuous `conv_valid`.
  - Expect 196 `pool_valid` pulses.
  - First window ch0 = 32'h00_01_1C_1D, one cycle after pixel (1,1).
  - `frame_done` occurs only with the 196th pulse.
- Random `conv_valid` gaps (0–5 idle cycles) on the same frame: identical window sequence, each window one cycle after its completing sample.
- Two consecutive frames with no idle cycle: the second frame's first window uses only second-frame row-0 data; 392 windows total.
- `clear` asserted with `conv_valid` at pixel (3,10): that sample is dropped, and the next sample is treated as (0,0). The window after the restarted row 1 completes is correct.
- Async `reset_n` pulse mid-row at pixel (5,7):
  - All outputs go to 0 immediately.
  - After release, a full frame produces 196 correct windows.
- Channel independence: ch3 = 8'hFF and all other channels = 8'h00 → `pool_ch3`=32'hFFFFFFFF, every other channel 32'h0, for every window.
